// File: rtl/delta_h_ctrl_pkg.sv
// delta_pkg: shared state encoding and defaults for the delta_h accumulation
// controller and its chunk index counter.
package delta_pkg;

   localparam int D_NUM   = 2;
   localparam int D_WIDTH = 16;
   localparam int D_MAXCH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/delta_h_ctrl_chunk_cnt.sv
// chunk_cnt: loadable chunk index counter with a terminal flag raised
// when the index reaches the latched chunk count minus one.
module chunk_cnt
   import delta_pkg::*;
#(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_load,
   input  logic          i_inc,
   input  logic [CW-1:0] i_n,
   output logic [CW-1:0] o_idx,
   output logic          o_last
);

   logic [CW-1:0] r_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx <= '0;
      end else if (i_load) begin
         r_idx <= '0;
      end else if (i_inc) begin
         r_idx <= r_idx + CW'(1);
      end
   end

   assign o_idx  = r_idx;
   assign o_last = (r_idx == (i_n - CW'(1)));

endmodule

// File: rtl/delta_h_ctrl.sv
// delta_h_ctrl: sequences NUM-wide chunks into the delta accumulator.
// Define DELTA_H_CTRL_TIMEOUT_EN to abort stalled operations after TMO cycles.
module delta_h_ctrl
   import delta_pkg::*;
#(
   parameter int NUM   = D_NUM,
   parameter int MAXCH = D_MAXCH,
   parameter int CW    = 4,
   parameter int TMO   = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_start,
   input  logic [CW-1:0] i_nchunk,
   input  logic          i_valid,
   output logic          o_ready,
   output logic          o_acc_en,
   output logic          o_clr,
   output logic [CW-1:0] o_idx,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_err
);

   state_e        r_state;
   logic [CW-1:0] r_n;
   logic [CW-1:0] w_n_sat;
   logic          w_xfer;
   logic          w_last;
   logic          w_start_ok;
   logic          w_tmo_hit;
   logic          w_unused;

   assign o_ready    = (r_state == ACCUM);
   assign w_xfer     = i_valid & o_ready;
   assign o_acc_en   = w_xfer;
   assign o_clr      = w_xfer & (o_idx == '0);
   assign o_busy     = (r_state == ACCUM) | (r_state == DONE);
   assign o_done     = (r_state == DONE);
   assign w_start_ok = i_start & (r_state == IDLE);

   // zero means one chunk; oversize requests clamp to the buffer depth
   always_comb begin
      w_n_sat = i_nchunk;
      if (i_nchunk == '0) begin
         w_n_sat = CW'(1);
      end else if (i_nchunk > CW'(MAXCH)) begin
         w_n_sat = CW'(MAXCH);
      end
   end

`ifdef DELTA_H_CTRL_TIMEOUT_EN
   localparam int TW = clog2(TMO) + 1;

   logic [TW-1:0] r_tmo;
   logic          r_err;

   assign w_tmo_hit = o_ready & ~w_xfer & (r_tmo == TW'(TMO - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmo <= '0;
         r_err <= 1'b0;
      end else begin
         r_err <= w_tmo_hit;
         if (!o_ready || w_xfer || w_tmo_hit) begin
            r_tmo <= '0;
         end else begin
            r_tmo <= r_tmo + TW'(1);
         end
      end
   end

   assign o_err = r_err;
`else
   assign w_tmo_hit = 1'b0;
   assign o_err     = 1'b0;
`endif

   assign w_unused = ^{NUM[0], TMO[0], D_WIDTH[0],
                       (CW >= clog2(MAXCH + 1))};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_n     <= CW'(1);
      end else begin
         unique case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_n     <= w_n_sat;
                  r_state <= ACCUM;
               end
            end
            ACCUM: begin
               if (w_tmo_hit) begin
                  r_state <= IDLE;
               end else if (w_xfer && w_last) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   chunk_cnt #(
      .CW(CW)
   ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_load(w_start_ok),
      .i_inc (w_xfer & ~w_last),
      .i_n   (r_n),
      .o_idx (o_idx),
      .o_last(w_last)
   );

endmodule

// File: tb/tb_delta_h_ctrl.sv
// Scoreboard bench for delta_h_ctrl: stimulus queues expected transfers,
// done and err events; a negedge monitor pops and compares them.
module tb_delta_h_ctrl;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_start = 1'b0;
   logic [CW-1:0] i_nchunk = '0;
   logic          i_valid = 1'b0;
   logic          o_ready, o_acc_en, o_clr, o_busy, o_done, o_err;
   logic [CW-1:0] o_idx;

   delta_h_ctrl #(
      .NUM(2), .MAXCH(8), .CW(CW), .TMO(16)
   ) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_nchunk(i_nchunk),
      .i_valid(i_valid), .o_ready(o_ready), .o_acc_en(o_acc_en),
      .o_clr(o_clr), .o_idx(o_idx), .o_busy(o_busy),
      .o_done(o_done), .o_err(o_err)
   );

   always #5 clk = ~clk;

   typedef enum int {EV_XFER, EV_DONE, EV_ERR} ev_e;
   typedef struct {
      ev_e kind;
      int  rel;
      int  idx;
      int  clr;
      int  acc;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   t0 = 0;
   int   pd[16];
   int   wt[16];
   int   acc;

   always @(posedge clk) cyc <= cyc + 1;

   // reference datapath: two products per chunk into one accumulator
   always @(posedge clk or posedge rst) begin
      if (rst) acc <= 0;
      else if (o_acc_en)
         acc <= (o_clr ? 0 : acc)
                + pd[2*o_idx] * wt[2*o_idx]
                + pd[2*o_idx+1] * wt[2*o_idx+1];
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  nm, act, exp, cyc - t0);
      end
   endtask

   function automatic void push(ev_e k, int rel, int idx, int clr, int a);
      exp_t e;
      e.kind = k;
      e.rel  = rel;
      e.idx  = idx;
      e.clr  = clr;
      e.acc  = a;
      q.push_back(e);
   endfunction

   task automatic pop_chk(input ev_e k);
      exp_t e;
      if (q.size() == 0) begin
         chk($sformatf("unexpected event %s", k.name()), 1, 0);
         return;
      end
      e = q.pop_front();
      chk("event kind", int'(k), int'(e.kind));
      chk("event cycle", cyc - t0, e.rel);
      if (k == EV_XFER) begin
         chk("xfer idx", int'(o_idx), e.idx);
         chk("xfer clr", int'(o_clr), e.clr);
      end
      if (k == EV_DONE) chk("done acc", acc, e.acc);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (o_acc_en) pop_chk(EV_XFER);
         if (o_done) pop_chk(EV_DONE);
         if (o_err) pop_chk(EV_ERR);
         if (o_clr && !o_acc_en) chk("clr without xfer", 1, 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int n);
      i_start  = 1'b1;
      i_nchunk = CW'(n);
      t0       = cyc;
      tick();
      i_start  = 1'b0;
   endtask

   task automatic drain(input int maxc);
      int k;
      k = 0;
      while ((q.size() != 0 || o_busy) && k < maxc) begin
         tick();
         k++;
      end
      chk("drain", int'(q.size() == 0 && !o_busy), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         pd[i] = i + 1;
         wt[i] = 2 * i + 3;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst ready", int'(o_ready), 0);
      chk("rst busy", int'(o_busy), 0);
      chk("rst acc_en", int'(o_acc_en), 0);
      chk("rst idx", int'(o_idx), 0);
      chk("rst done", int'(o_done), 0);
      chk("rst err", int'(o_err), 0);
      rst = 1'b0;
      tick();

      // single chunk
      push(EV_XFER, 1, 0, 1, 0);
      push(EV_DONE, 2, 0, 0, 13);
      i_valid = 1'b1;
      start(1);
      drain(20);

      // four chunks back to back
      for (int i = 0; i < 4; i++) push(EV_XFER, i + 1, i, int'(i == 0), 0);
      push(EV_DONE, 5, 0, 0, 444);
      start(4);
      drain(20);

      // stall five cycles before idx 1
      push(EV_XFER, 1, 0, 1, 0);
      push(EV_XFER, 7, 1, 0, 0);
      push(EV_XFER, 8, 2, 0, 0);
      push(EV_DONE, 9, 0, 0, 203);
      start(3);
      tick();
      i_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall acc_en", int'(o_acc_en), 0);
         chk("stall idx", int'(o_idx), 1);
         chk("stall acc", acc, 13);
         tick();
      end
      i_valid = 1'b1;
      drain(20);

      // zero chunk count acts as one
      push(EV_XFER, 1, 0, 1, 0);
      push(EV_DONE, 2, 0, 0, 13);
      start(0);
      drain(20);

      // oversize count clamps to 8, stray start ignored
      for (int i = 0; i < 8; i++) push(EV_XFER, i + 1, i, int'(i == 0), 0);
      push(EV_DONE, 9, 0, 0, 3128);
      start(12);
      tick();
      tick();
      i_start  = 1'b1;
      i_nchunk = CW'(2);
      tick();
      i_start  = 1'b0;
      drain(30);

      // reset after second of four transfers
      push(EV_XFER, 1, 0, 1, 0);
      push(EV_XFER, 2, 1, 0, 0);
      start(4);
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("mid rst ready", int'(o_ready), 0);
      chk("mid rst acc_en", int'(o_acc_en), 0);
      chk("mid rst clr", int'(o_clr), 0);
      chk("mid rst busy", int'(o_busy), 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post rst ready", int'(o_ready), 0);
      chk("post rst busy", int'(o_busy), 0);
      chk("post rst idx", int'(o_idx), 0);
      chk("post rst done", int'(o_done), 0);
      chk("post rst queue", q.size(), 0);
      tick();
      push(EV_XFER, 1, 0, 1, 0);
      push(EV_XFER, 2, 1, 0, 0);
      push(EV_DONE, 3, 0, 0, 70);
      start(2);
      drain(20);

      // long stall: abort with macro, wait without it
      i_valid = 1'b0;
`ifdef DELTA_H_CTRL_TIMEOUT_EN
      push(EV_ERR, 17, 0, 0, 0);
      start(2);
      drain(40);
      chk("tmo ready", int'(o_ready), 0);
`else
      start(2);
      repeat (20) tick();
      @(negedge clk);
      chk("wait busy", int'(o_busy), 1);
      chk("wait ready", int'(o_ready), 1);
      chk("wait idx", int'(o_idx), 0);
      chk("wait err", int'(o_err), 0);
      push(EV_XFER, 21, 0, 1, 0);
      push(EV_XFER, 22, 1, 0, 0);
      push(EV_DONE, 23, 0, 0, 70);
      i_valid = 1'b1;
      drain(20);
`endif

      repeat (3) tick();
      chk("final queue", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/delta_h_ctrl.md
DELTA_H_CTRL -- requirements
Module: delta_h_ctrl

Interface
REQ-001 The module SHALL have parameter NUM, default 2, meaning the number of (prevd, w) pairs per chunk; it is informational and matches the datapath width.
REQ-002 The module SHALL have parameter MAXCH, default 8, meaning the maximum number of chunks per delta.
REQ-003 The module SHALL have parameter CW, default 4, meaning the chunk-count and index width; CW SHALL be at least clog2(MAXCH+1).
REQ-004 The module SHALL have parameter TMO, default 16, meaning the timeout cycle limit; it is used only with the timeout macro.
REQ-005 The module SHALL have port clk, input, 1 bit: the clock.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The module SHALL have port i_start, input, 1 bit: a 1-cycle request to begin a new delta accumulation.
REQ-008 The module SHALL have port i_nchunk, input, CW bits: the chunk count, sampled on an accepted i_start.
REQ-009 The module SHALL have port i_valid, input, 1 bit: the upstream chunk (prevd/w slice) is present.
REQ-010 The module SHALL have port o_ready, output, 1 bit: the controller accepts a chunk this cycle.
REQ-011 The module SHALL have port o_acc_en, output, 1 bit: the datapath accumulator register loads this cycle.
REQ-012 The module SHALL have port o_clr, output, 1 bit: the datapath selects 0 instead of the accumulator feedback (first chunk).
REQ-013 The module SHALL have port o_idx, output, CW bits: the index of the current chunk, used as the weight/delta memory address.
REQ-014 The module SHALL have port o_busy, output, 1 bit: a computation is in progress.
REQ-015 The module SHALL have port o_done, output, 1 bit: a 1-cycle pulse indicating the datapath output holds the final delta.
REQ-016 The module SHALL have port o_err, output, 1 bit: a 1-cycle pulse indicating a timeout abort.

Function
REQ-017 The FSM SHALL have the states IDLE, ACCUM and DONE.
REQ-018 In IDLE, i_start SHALL latch the chunk count: N = i_nchunk, with 0 mapped to 1 and values greater than MAXCH saturated to MAXCH. The FSM SHALL clear o_idx and go to ACCUM.
REQ-019 i_start SHALL be ignored in ACCUM and DONE, with no effect on the count, the index or the state.
REQ-020 o_ready SHALL be 1 exactly when the state is ACCUM; a transfer SHALL occur when i_valid and o_ready are both 1.
REQ-021 o_acc_en SHALL equal the transfer condition combinationally, so the datapath register loads only on transfers and holds otherwise.
REQ-022 o_clr SHALL be 1 on a transfer when o_idx equals 0; otherwise o_clr SHALL be 0.
REQ-023 o_idx SHALL increment by 1 after each transfer, except the last transfer, where o_idx equals N-1; it SHALL never wrap within an operation.
REQ-024 After the transfer with o_idx equal to N-1, the FSM SHALL go to DONE on the next edge.
REQ-025 DONE SHALL last exactly 1 cycle, with o_done equal to 1, then the FSM SHALL return to IDLE.
REQ-026 o_done SHALL occur exactly 1 cycle after the last transfer.
REQ-027 o_busy SHALL be 1 in ACCUM and DONE.
REQ-028 i_valid stalls (low) in ACCUM SHALL hold the state, o_idx and the datapath register without limit, unless the timeout macro is defined.
REQ-029 o_idx SHALL hold its last value in DONE and IDLE.

Reset
REQ-030 rst SHALL force, at any time including mid-operation, the state to IDLE, o_idx to 0, the latched N to 1, the timeout counter to 0, and o_done and o_err to 0.
REQ-031 A chunk in flight at the time of reset SHALL be discarded, with no o_done issued.
REQ-032 While rst is high, o_ready, o_acc_en, o_clr and o_busy SHALL be 0.

Configuration
REQ-033 With DELTA_H_CTRL_TIMEOUT_EN defined, a counter SHALL increment for each ACCUM cycle without a transfer and clear on every transfer.
REQ-034 With DELTA_H_CTRL_TIMEOUT_EN defined, when the counter reaches TMO-1 with no transfer, the FSM SHALL go to IDLE next cycle, pulse o_err for 1 cycle, and issue no o_done.
REQ-035 Without DELTA_H_CTRL_TIMEOUT_EN, the counter SHALL be absent, o_err SHALL be tied to 0, and the TMO parameter SHALL be unused.

Structure
REQ-036 The package delta_pkg SHALL hold the FSM state enum (IDLE/ACCUM/DONE), the default NUM, WIDTH and MAXCH constants, and a clog2 helper function.
REQ-037 The design SHALL have one sub-module, chunk_cnt: a loadable CW-bit up-counter with terminal flag (idx equal to N-1) used for o_idx; the timeout counter SHALL be inline.

Verification
REQ-038 Bench scenario, single chunk: start with nchunk=1 and valid held high -> one transfer with clr=1 and idx=0, then done 1 cycle later; total 3 cycles from start to done.
REQ-039 Bench scenario, four chunks, back-to-back: start with nchunk=4 and valid high -> idx sequence 0,1,2,3; clr only on idx 0; done on cycle 6 after start; datapath result equals the sum of all 8 products.
REQ-040 Bench scenario, stalls: nchunk=3 with valid low for 5 cycles before idx 1 -> acc_en=0 during the stall, idx frozen at 1, accumulator unchanged, done 1 cycle after the third transfer.
REQ-041 Bench scenario, boundaries: nchunk=0 behaves as 1; nchunk=12 with MAXCH=8 produces exactly 8 transfers; a start pulse during ACCUM leaves idx and the count unchanged.
REQ-042 Bench scenario, mid-operation reset: assert rst after the 2nd of 4 transfers -> next cycle IDLE, ready=0, no done; a following start with nchunk=2 completes normally.
REQ-043 Bench scenario, timeout with macro defined and TMO=16: valid low for 16 cycles in ACCUM -> err pulse, return to IDLE, done never asserted; without the macro the same stimulus waits and err stays 0.
